// File: rtl/key_disp_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | key_disp_pkg : shared types for the key capture / digit scan path            |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
package key_disp_pkg;

   localparam int CODE_W = 3;
   localparam int BCD_W  = 4;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PRESS_DB = 2'd1,
      HELD     = 2'd2,
      REL_DB   = 2'd3
   } kd_state_t;

   typedef struct packed {
      logic              valid;
      logic [CODE_W-1:0] code;
   } kd_entry_t;

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | key_debounce : press/release debounce FSM, raises accept on the edge that    |
// | takes the DEB_CYC-th matching press sample.                Rev 1.0           |
// +-----------------------------------------------------------------------------+
module key_debounce
   import key_disp_pkg::*;
#(
   parameter int DEB_CYC = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              press,
   input  logic [CODE_W-1:0] code,
   output logic              accept,
   output logic [CODE_W-1:0] accept_code
);

   localparam int              CNT_W  = $clog2(DEB_CYC);
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DEB_CYC - 1);
   localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

   kd_state_t         state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [CODE_W-1:0] latched, latched_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         latched <= '0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         latched <= latched_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      latched_nxt = latched;
      accept      = 1'b0;
      case (state)
         IDLE: begin
            if (press) begin
               state_nxt   = PRESS_DB;
               cnt_nxt     = C_ONE;
               latched_nxt = code;
            end
         end
         PRESS_DB: begin
            if (!press) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else if (code != latched) begin
               latched_nxt = code;
               cnt_nxt     = C_ONE;
            end else if (cnt == C_LAST) begin
               // this sample is the DEB_CYC-th identical one
               state_nxt = HELD;
               cnt_nxt   = '0;
               accept    = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         HELD: begin
            if (!press) begin
               state_nxt = REL_DB;
               cnt_nxt   = C_ONE;
            end
         end
         REL_DB: begin
            if (press) begin
               state_nxt = HELD;
               cnt_nxt   = '0;
            end else if (cnt == C_LAST) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   assign accept_code = latched;

endmodule
`default_nettype wire

// File: rtl/key_disp_scheduler.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | key_disp_scheduler : debounced key history buffer with time-multiplexed      |
// | BCD digit scan for a shared decoder.                       Rev 1.0           |
// +-----------------------------------------------------------------------------+
module key_disp_scheduler
   import key_disp_pkg::*;
#(
   parameter  int NDIG     = 4,
   parameter  int DEB_CYC  = 8,
   parameter  int SCAN_DIV = 4,
   localparam int FILL_W   = $clog2(NDIG + 1)
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [CODE_W-1:0] A_N,
   input  logic              GS_N,
   input  logic              CLR,
   output logic [BCD_W-1:0]  D,
   output logic              BI,
   output logic [NDIG-1:0]   DIG_SEL,
   output logic              KEY_VALID,
   output logic [CODE_W-1:0] KEY_CODE,
   output logic [FILL_W-1:0] FILL
);

   localparam int               IDX_W    = $clog2(NDIG);
   localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NDIG - 1);
   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(NDIG);

   logic              accept;
   logic [CODE_W-1:0] acc_code;
   logic              push;

   kd_entry_t         entries     [NDIG];
   kd_entry_t         entries_nxt [NDIG];
   kd_entry_t         disp;
   logic [FILL_W-1:0] fill_nxt;
   logic [DIV_W-1:0]  div, div_nxt;
   logic [IDX_W-1:0]  idx, idx_nxt;

   key_debounce #(
      .DEB_CYC (DEB_CYC)
   ) u_debounce (
      .clk         (CLK),
      .rst         (RST),
      .press       (~GS_N),
      .code        (~A_N),
      .accept      (accept),
      .accept_code (acc_code)
   );

   always_comb begin
      entries_nxt = entries;
      fill_nxt    = FILL;
      push        = accept & ~CLR;
      if (CLR) begin
         for (int i = 0; i < NDIG; i++) entries_nxt[i] = '0;
         fill_nxt = '0;
      end else if (accept) begin
         entries_nxt[0] = {1'b1, acc_code};
         for (int i = 1; i < NDIG; i++) entries_nxt[i] = entries[i-1];
         if (FILL != FILL_MAX) fill_nxt = FILL + 1'b1;
      end

      div_nxt = div + 1'b1;
      idx_nxt = idx;
      if (div == DIV_LAST) begin
         div_nxt = '0;
         idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
      // display outputs are registered from next-state so they track the buffer without lag
      disp = entries_nxt[idx_nxt];
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < NDIG; i++) entries[i] <= '0;
         FILL      <= '0;
         div       <= '0;
         idx       <= '0;
         D         <= '0;
         BI        <= 1'b0;
         DIG_SEL   <= {{(NDIG-1){1'b0}}, 1'b1};
         KEY_VALID <= 1'b0;
         KEY_CODE  <= '0;
      end else begin
         entries   <= entries_nxt;
         FILL      <= fill_nxt;
         div       <= div_nxt;
         idx       <= idx_nxt;
         D         <= {1'b0, disp.code};
         BI        <= disp.valid;
         DIG_SEL   <= {{(NDIG-1){1'b0}}, 1'b1} << idx_nxt;
         KEY_VALID <= push;
         if (push) KEY_CODE <= acc_code;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_key_disp_scheduler.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_key_disp_scheduler : directed + random bench against a run-length model.  |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module tb_key_disp_scheduler;

   localparam int NDIG = 4;
   localparam int DEB  = 8;
   localparam int SCAN = 4;

   logic       clk = 1'b0;
   logic       rst, gs_n, clr;
   logic [2:0] a_n;
   logic [3:0] d;
   logic       bi, key_valid;
   logic [NDIG-1:0] dig_sel;
   logic [2:0] key_code;
   logic [2:0] fill;

   int total = 0;
   int bad   = 0;

   // reference model: press/release run lengths and a newest-first code history
   bit         m_held;
   int         m_run;
   logic [2:0] m_code;
   logic [2:0] m_q[$];
   int         m_t;
   bit         m_kv;
   logic [2:0] m_kc;

   always #5 clk = ~clk;

   key_disp_scheduler #(
      .NDIG     (NDIG),
      .DEB_CYC  (DEB),
      .SCAN_DIV (SCAN)
   ) dut (
      .CLK       (clk),
      .RST       (rst),
      .A_N       (a_n),
      .GS_N      (gs_n),
      .CLR       (clr),
      .D         (d),
      .BI        (bi),
      .DIG_SEL   (dig_sel),
      .KEY_VALID (key_valid),
      .KEY_CODE  (key_code),
      .FILL      (fill)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge(input bit r, input bit press, input logic [2:0] code, input bit c);
      bit acc;
      acc  = 1'b0;
      m_kv = 1'b0;
      if (r) begin
         m_held = 1'b0;
         m_run  = 0;
         m_code = '0;
         m_q.delete();
         m_t    = 0;
         m_kc   = '0;
         return;
      end
      if (!m_held) begin
         if (!press)                          m_run = 0;
         else if (m_run > 0 && code == m_code) m_run++;
         else begin
            m_run  = 1;
            m_code = code;
         end
         if (m_run == DEB) begin
            acc    = 1'b1;
            m_held = 1'b1;
            m_run  = 0;
         end
      end else begin
         if (press) m_run = 0;
         else       m_run++;
         if (m_run == DEB) begin
            m_held = 1'b0;
            m_run  = 0;
         end
      end
      m_t++;
      if (c) m_q.delete();
      else if (acc) begin
         m_q.push_front(code);
         if (m_q.size() > NDIG) void'(m_q.pop_back());
         m_kv = 1'b1;
         m_kc = code;
      end
   endtask

   task automatic check_all();
      int  idx;
      bit  v;
      idx = (m_t / SCAN) % NDIG;
      v   = (idx < m_q.size());
      chk("key_valid", key_valid, m_kv);
      chk("key_code", key_code, m_kc);
      chk("fill", fill, m_q.size());
      chk("dig_sel", dig_sel, 32'd1 << idx);
      chk("bi", bi, v);
      chk("d3", d[3], 1'b0);
      if (v) chk("d", d, m_q[idx]);
   endtask

   task automatic cyc(input bit r, input bit press, input logic [2:0] code, input bit c);
      rst  = r;
      gs_n = ~press;
      a_n  = ~code;
      clr  = c;
      @(posedge clk);
      model_edge(r, press, code, c);
      #1;
      check_all();
   endtask

   task automatic hold(input logic [2:0] code, input int n);
      repeat (n) cyc(0, 1, code, 0);
   endtask

   task automatic rel(input int n);
      repeat (n) cyc(0, 0, 3'd0, 0);
   endtask

   initial begin
      rst = 1'b1; gs_n = 1'b1; a_n = 3'b111; clr = 1'b0;
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
      chk("rst_dig_sel", dig_sel, 4'b0001);
      chk("rst_bi", bi, 1'b0);
      chk("rst_d", d, 4'd0);

      // 1: clean key5 press, then scan through all digits
      hold(3'd5, 8);
      chk("t1_valid", key_valid, 1'b1);
      chk("t1_code", key_code, 3'd5);
      chk("t1_fill", fill, 3'd1);
      rel(8 + NDIG * SCAN);

      // 2: glitched press, then clean press
      hold(3'd5, 4); rel(1); hold(3'd5, 3);
      chk("t2_noacc", key_valid, 1'b0);
      hold(3'd5, 5);
      chk("t2_acc", key_valid, 1'b1);
      rel(8);

      // 3: code changes mid-debounce
      hold(3'd5, 3); hold(3'd2, 8);
      chk("t3_code", key_code, 3'd2);
      rel(8);

      // 4: history overflow
      cyc(0, 0, 0, 1);
      foreach (m_code[i]) ; // no-op keeps loop var local style consistent
      hold(3'd1, 8); rel(8);
      hold(3'd2, 8); rel(8);
      hold(3'd3, 8); rel(8);
      hold(3'd4, 8); rel(8);
      hold(3'd6, 8); rel(8);
      chk("t4_fill", fill, 3'd4);
      rel(NDIG * SCAN);

      // 5: CLR coincides with the accept edge
      hold(3'd7, 7);
      cyc(0, 1, 3'd7, 1);
      chk("t5_valid", key_valid, 1'b0);
      chk("t5_fill", fill, 3'd0);
      rel(8 + NDIG * SCAN);

      // 6: reset mid-debounce
      hold(3'd3, 6);
      cyc(1, 1, 3'd3, 0);
      chk("t6_dig_sel", dig_sel, 4'b0001);
      chk("t6_valid", key_valid, 1'b0);
      hold(3'd3, 7);
      chk("t6_noacc", key_valid, 1'b0);
      hold(3'd3, 1);
      chk("t6_acc", key_valid, 1'b1);
      rel(8);

      // random segments
      for (int s = 0; s < 400; s++) begin
         bit         p;
         logic [2:0] k;
         int         len;
         p   = ($urandom_range(0, 1) == 1);
         k   = 3'($urandom_range(0, 7));
         len = $urandom_range(1, 12);
         for (int j = 0; j < len; j++) begin
            bit c, r;
            c = ($urandom_range(0, 39) == 0);
            r = ($urandom_range(0, 299) == 0);
            cyc(r, p, k, c);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
